// File: rtl/led_pattern_sequencer.sv
// Autonomous LED blink engine: software programs a pattern over its own Avalon-MM slave,
// the block then writes successive pattern bits into the LED PIO. Optional irq: LED_SEQ_IRQ_EN.
module led_pattern_sequencer #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned PAT_W = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata
`ifdef LED_SEQ_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int unsigned IdxW   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [6:0]  PatLen = 7'(PAT_W);

   typedef enum logic [1:0] {StIdle, StWrite, StCount, StStop} state_e;

   state_e           state_q, state_d;
   logic [5:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             en_q, en_d, done_q, done_d;
   logic             oneshot_q, clr_q;
   logic [CNT_W-1:0] period_q;
   logic [PAT_W-1:0] pattern_q;
   logic [5:0]       length_q;
   logic             irq_en_bit;

   logic       wr_en, ctrl_wr, abort;
   logic [6:0] eff_len;
   logic [5:0] cur_idx;
   logic       last, pat_bit;

   assign wr_en   = s_chipselect & ~s_write_n;
   assign ctrl_wr = wr_en & (s_address == 2'd0);
   assign abort   = ctrl_wr & ~s_writedata[0];

   assign eff_len = ((length_q == 6'd0) || ({1'b0, length_q} > PatLen)) ? PatLen
                                                                        : {1'b0, length_q};
   // A live LENGTH shrink can leave idx past the end; restart from bit 0 in that case.
   assign cur_idx = ({1'b0, idx_q} >= eff_len) ? 6'd0 : idx_q;
   assign last    = ({1'b0, cur_idx} == (eff_len - 7'd1));
   assign pat_bit = pattern_q[cur_idx[IdxW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (ctrl_wr && s_writedata[0] && !en_q) begin
               state_d = StWrite;
               idx_d   = '0;
            end
         end
         StWrite: begin
            cnt_d = period_q;
            if (oneshot_q && last) begin
               state_d = StStop;
               idx_d   = '0;
            end else begin
               idx_d   = last ? 6'd0 : cur_idx + 6'd1;
               state_d = (period_q != '0) ? StCount : StWrite;
            end
            if (abort) state_d = StStop;
         end
         StCount: begin
            cnt_d = cnt_q - CNT_W'(1);
            if ((cnt_q == '0) || (cnt_q == CNT_W'(1))) state_d = StWrite;
            if (abort) state_d = StStop;
         end
         StStop:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // A CTRL write overrides the EN clear of STOP, but STOP always sets DONE.
   always_comb begin
      en_d   = en_q;
      done_d = done_q;
      if (state_q == StStop) en_d = 1'b0;
      if (ctrl_wr) en_d = s_writedata[0];
      if (ctrl_wr && s_writedata[0]) done_d = 1'b0;
      if (state_q == StStop) done_d = 1'b1;
   end

   always_comb begin
      m_address    = 2'd0;
      m_chipselect = 1'b0;
      m_write_n    = 1'b1;
      m_writedata  = '0;
      unique case (state_q)
         StWrite: begin
            m_chipselect = 1'b1;
            m_write_n    = 1'b0;
            m_writedata  = {31'b0, pat_bit};
         end
         StStop: begin
            if (clr_q) begin
               m_chipselect = 1'b1;
               m_write_n    = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         oneshot_q <= 1'b0;
         clr_q     <= 1'b0;
         period_q  <= '0;
         pattern_q <= '0;
         length_q  <= '0;
      end else if (wr_en) begin
         unique case (s_address)
            2'd0: begin
               oneshot_q <= s_writedata[1];
               clr_q     <= s_writedata[2];
            end
            2'd1:    period_q  <= s_writedata[CNT_W-1:0];
            2'd2:    pattern_q <= s_writedata[PAT_W-1:0];
            default: length_q  <= s_writedata[5:0];
         endcase
      end
   end

`ifdef LED_SEQ_IRQ_EN
   logic irq_en_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en_q <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (ctrl_wr) irq_en_q <= s_writedata[4];
         irq <= done_q & irq_en_q;
      end
   end

   assign irq_en_bit = irq_en_q;
`else
   assign irq_en_bit = 1'b0;
`endif

   always_comb begin
      s_readdata = '0;
      unique case (s_address)
         2'd0:    s_readdata = {27'b0, irq_en_bit, done_q, clr_q, oneshot_q, en_q};
         2'd1:    s_readdata = 32'(period_q);
         2'd2:    s_readdata = 32'(pattern_q);
         default: s_readdata = {26'b0, length_q};
      endcase
   end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer: expected LED strobes (cycle + data) are queued
// when a sequence is started and checked by a negedge monitor as the DUT emits them.
module tb_led_pattern_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  s_address = 2'd0;
   logic        s_chipselect = 1'b0;
   logic        s_write_n = 1'b1;
   logic [31:0] s_writedata = '0;
   logic [31:0] s_readdata;
   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
`ifdef LED_SEQ_IRQ_EN
   logic        irq;
`endif

   led_pattern_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_address    (s_address),
      .s_chipselect (s_chipselect),
      .s_write_n    (s_write_n),
      .s_writedata  (s_writedata),
      .s_readdata   (s_readdata),
      .m_address    (m_address),
      .m_chipselect (m_chipselect),
      .m_write_n    (m_write_n),
      .m_writedata  (m_writedata)
`ifdef LED_SEQ_IRQ_EN
      ,
      .irq          (irq)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic push(input int unsigned c, input logic [31:0] d);
      exp_t e;
      e.cyc  = c;
      e.data = d;
      q.push_back(e);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      s_address    = a;
      s_writedata  = d;
      s_chipselect = 1'b1;
      s_write_n    = 1'b0;
      @(posedge clk);
      #1;
      s_chipselect = 1'b0;
      s_write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      s_address = a;
      #1;
      check(tag, s_readdata, exp);
   endtask

   // Wait (bounded) until at most n expected strobes remain outstanding.
   task automatic wait_q(input int n, input int bound, input string tag);
      for (int i = 0; i < bound; i++) begin
         if (q.size() <= n) break;
         @(posedge clk);
      end
      check(tag, q.size(), n);
   endtask

   // Every strobe must have been predicted, at the predicted cycle, with the predicted data.
   always @(negedge clk) begin
      if (reset_n && m_chipselect && !m_write_n) begin
         exp_t e;
         check("strobe_expected", 32'(q.size() > 0), 32'd1);
         check("m_address", {30'b0, m_address}, 32'd0);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("strobe_cyc", cyc, e.cyc);
            check("strobe_data", m_writedata, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned w;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs", {31'b0, m_chipselect}, 32'd0);
      check("rst_wn", {31'b0, m_write_n}, 32'd1);
      check("rst_wd", m_writedata, 32'd0);
      rd(2'd0, 32'd0, "rst_ctrl");
      rd(2'd1, 32'd0, "rst_period");
      rd(2'd2, 32'd0, "rst_pattern");
      rd(2'd3, 32'd0, "rst_length");
      reset_n = 1'b1;

      // Register masking and optional IRQ_EN bit
      wr(2'd3, 32'hFF);
      rd(2'd3, 32'h3F, "length_mask");
      wr(2'd2, 32'hA5A5_0F0F);
      rd(2'd2, 32'hA5A5_0F0F, "pattern_rb");
      wr(2'd0, 32'h10);
`ifdef LED_SEQ_IRQ_EN
      rd(2'd0, 32'h10, "ctrl_bit4");
`else
      rd(2'd0, 32'h00, "ctrl_bit4");
`endif
      wr(2'd0, 32'h0);

      // Reset mid-COUNT
      wr(2'd1, 32'd10);
      wr(2'd2, 32'h1);
      wr(2'd3, 32'd1);
      wr(2'd0, 32'h1);
      push(cyc, 32'd1);
      wait_q(0, 20, "rst_mid_drain");
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_cs", {31'b0, m_chipselect}, 32'd0);
      check("midrst_wn", {31'b0, m_write_n}, 32'd1);
      check("midrst_wd", m_writedata, 32'd0);
      rd(2'd0, 32'd0, "midrst_ctrl");
      rd(2'd1, 32'd0, "midrst_period");
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (20) @(posedge clk);

      // Periodic pattern 1011, LENGTH 4, PERIOD 3; redundant EN write mid-run
      wr(2'd1, 32'd3);
      wr(2'd3, 32'd4);
      wr(2'd2, 32'hB);
      wr(2'd0, 32'h1);
      w = cyc;
      for (int k = 0; k < 6; k++) push(w + 4 * k, (k % 4 == 2) ? 32'd0 : 32'd1);
      wait_q(3, 40, "p3_first3");
      wr(2'd0, 32'h1);
      wait_q(0, 40, "p3_drain");
      wr(2'd0, 32'h0);
      repeat (10) @(posedge clk);
      rd(2'd0, 32'h08, "p3_abort_ctrl");

      // One-shot with CLR_ON_STOP, PERIOD 0
      wr(2'd1, 32'd0);
      wr(2'd3, 32'd2);
      wr(2'd2, 32'h1);
      wr(2'd0, 32'h7);
      w = cyc;
      push(w, 32'd1);
      push(w + 1, 32'd0);
      push(w + 2, 32'd0);
      wait_q(0, 20, "oneshot_drain");
      repeat (2) @(posedge clk);
      rd(2'd0, 32'h0E, "oneshot_ctrl");

      // Abort during COUNT with PERIOD 10, then restart from idx 0
      wr(2'd1, 32'd10);
      wr(2'd3, 32'd4);
      wr(2'd2, 32'h9);
      wr(2'd0, 32'h1);
      w = cyc;
      push(w, 32'd1);
      push(w + 11, 32'd0);
      wait_q(0, 40, "abort_drain");
      wr(2'd0, 32'h0);
      repeat (15) @(posedge clk);
      rd(2'd0, 32'h08, "abort_ctrl");
      wr(2'd0, 32'h1);
      w = cyc;
      push(w, 32'd1);
      push(w + 11, 32'd0);
      wait_q(0, 40, "restart_drain");
      wr(2'd0, 32'h0);
      repeat (5) @(posedge clk);

      // Live LENGTH shrink while idx is 6 of 8
      wr(2'd1, 32'd3);
      wr(2'd3, 32'd8);
      wr(2'd2, 32'h23);
      wr(2'd0, 32'h1);
      w = cyc;
      for (int k = 0; k < 6; k++) push(w + 4 * k, (k == 0 || k == 1 || k == 5) ? 32'd1 : 32'd0);
      wait_q(0, 60, "len8_drain");
      wr(2'd3, 32'd4);
      push(w + 24, 32'd1);
      push(w + 28, 32'd1);
      push(w + 32, 32'd0);
      push(w + 36, 32'd0);
      push(w + 40, 32'd1);
      wait_q(0, 60, "len4_drain");
      wr(2'd0, 32'h0);
      repeat (5) @(posedge clk);

      // LENGTH 0 means 32 steps: wrap after bit 31
      wr(2'd1, 32'd0);
      wr(2'd3, 32'd0);
      wr(2'd2, 32'h8000_0001);
      wr(2'd0, 32'h1);
      w = cyc;
      for (int k = 0; k < 34; k++)
         push(w + k, ((k % 32) == 0 || (k % 32) == 31) ? 32'd1 : 32'd0);
      repeat (32) @(posedge clk);
      wr(2'd0, 32'h0);
      wait_q(0, 10, "len0_drain");
      repeat (5) @(posedge clk);

`ifdef LED_SEQ_IRQ_EN
      // irq follows DONE by one cycle; a restart clears both
      wr(2'd3, 32'd1);
      wr(2'd2, 32'h1);
      wr(2'd0, 32'h13);
      w = cyc;
      push(w, 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("irq_w1", {31'b0, irq}, 32'd0);
      @(negedge clk);
      check("irq_w2", {31'b0, irq}, 32'd0);
      rd(2'd0, 32'h1A, "irq_ctrl_done");
      @(negedge clk);
      check("irq_w3", {31'b0, irq}, 32'd1);
      wr(2'd1, 32'd100);
      wr(2'd0, 32'h11);
      push(cyc, 32'd1);
      @(negedge clk);
      rd(2'd0, 32'h11, "irq_ctrl_clr");
      @(negedge clk);
      check("irq_clr", {31'b0, irq}, 32'd0);
      wr(2'd0, 32'h0);
      repeat (5) @(posedge clk);
`endif

      check("final_queue", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Autonomous blink/pattern engine for the single-bit LED PIO in the SPI platform.
- Software configures it through its own Avalon-MM slave (pattern, step period, length, mode).
- The block then acts as the sole Avalon-MM writer into the LED PIO slave. It issues one-cycle writes of successive pattern bits at a programmed interval, so the CPU does not bit-bang the LED.

Parameters:
- CNT_W, 32, width of PERIOD register and step counter.
- PAT_W, 32, pattern width in bits; LENGTH range is 1..PAT_W.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- s_address  input  2  slave register select.
- s_chipselect  input  1  slave select.
- s_write_n  input  1  slave write strobe, active low.
- s_writedata  input  32  slave write data.
- s_readdata  output  32  slave read data, zero wait-state, combinational.
- m_address  output  2  to LED PIO address; constant 0.
- m_chipselect  output  1  to LED PIO chipselect.
- m_write_n  output  1  to LED PIO write_n.
- m_writedata  output  32  to LED PIO writedata.
- irq  output  1  present only with LED_SEQ_IRQ_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- Register map (word addresses):
  - 0 CTRL: bit0 EN, bit1 ONESHOT, bit2 CLR_ON_STOP, bit3 DONE (read-only, sticky), bit4 IRQ_EN (see optional feature).
  - 1 PERIOD.
  - 2 PATTERN.
  - 3 LENGTH [5:0].
  - Unused bits read 0.
- Slave timing: a write occurs when s_chipselect=1 and s_write_n=0, registered on the clk edge. Reads are combinational, with no side effects.
- Reset values: all registers 0; state IDLE; idx 0; counter 0; m_chipselect 0; m_write_n 1; m_writedata 0; irq 0; m_address always 0.
- Effective values: LENGTH of 0 or >PAT_W is treated as PAT_W. PERIOD is used as-is.
- Master strobe: a WRITE cycle drives m_chipselect=1, m_write_n=0 and m_writedata={31'b0, PATTERN[idx]} for exactly one cycle. The PIO has no waitrequest, so every strobe completes in that cycle.
- States: IDLE, WRITE, COUNT, STOP.
  - IDLE: on an EN rising edge (0->1 via a CTRL write) go to WRITE on the next cycle, with idx=0 and DONE cleared.
  - WRITE: strobe PATTERN[idx]; load counter=PERIOD.
    - If ONESHOT=1 and idx==LENGTH-1: go to STOP.
    - Otherwise idx <= (idx==LENGTH-1) ? 0 : idx+1. Go to COUNT if PERIOD!=0, else WRITE.
  - COUNT: decrement counter; when counter==1 go to WRITE. Strobe spacing is PERIOD+1 cycles (PERIOD=0 gives a strobe every cycle).
  - STOP: clear EN and set DONE.
    - If CLR_ON_STOP=1: emit one strobe with writedata 0 in this cycle.
    - Go to IDLE.
- Abort: a CTRL write with EN=0 while in WRITE or COUNT means no further pattern strobes; the next state is STOP.
  - A strobe in the same cycle as the aborting write still completes.
  - DONE is set on abort as well.
- Restart: writing EN=1 while already EN=1 is not a rising edge. No restart; idx continues.
- Live updates: PATTERN, PERIOD and LENGTH writes while running take effect at the next WRITE/counter load.
  - If idx >= the new LENGTH at a WRITE, that WRITE uses idx=0 instead.
- Same-cycle CTRL write and STOP: the slave CTRL write wins for EN; DONE is still set.
- DONE: cleared by a CTRL write with EN=1.
- Reset mid-sequence: everything returns to reset values immediately. The LED PIO retains its last value; this block does not write it on reset.

Optional Feature:
- LED_SEQ_IRQ_EN defined:
  - irq port exists; irq = DONE & IRQ_EN, registered.
  - CTRL bit4 is R/W.
- Not defined:
  - No irq port.
  - CTRL bit4 is write-ignored and reads 0.
  - DONE is polled only.

Test Plan:
- Reset asserted mid-COUNT -> outputs at reset values, m_write_n=1, s_readdata of CTRL=0, no strobe after deassert until EN written.
- PATTERN=0b1011, LENGTH=4, PERIOD=3, CTRL=0x1:
  - first strobe 1 cycle after the CTRL write;
  - strobes every 4 cycles with data 1,1,0,1,1,1,...
- PERIOD=0, LENGTH=2, PATTERN=0b01, ONESHOT=1, CLR_ON_STOP=1 -> strobes 1,0 on consecutive cycles, then STOP strobe 0. CTRL reads 0x0E (EN cleared, DONE set).
- Running with PERIOD=10: write CTRL=0 during COUNT -> no further pattern strobes, DONE=1. Rewriting CTRL=0x1 restarts at idx 0.
- Running with LENGTH=8 and idx=6: write LENGTH=4 -> next strobe uses PATTERN[0]. LENGTH=0 -> wraps after 32 steps.
- With LED_SEQ_IRQ_EN, CTRL=0x13 (EN|ONESHOT|IRQ_EN) -> irq rises 1 cycle after DONE sets; writing CTRL=0x11 clears DONE and irq.
